// File: rtl/wb_pkg.sv
// Shared widths, requester identifiers and helpers for the writeback arbiter.
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] v;
    v     = '0;
    v[rd] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry holding register for a single writeback channel.
module wb_slot
  import wb_pkg::*;
#(
  parameter int N = XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [REG_ADDR_W-1:0] load_rd,
  input  logic [N-1:0]          load_data,
  output logic                  full,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [N-1:0]          data
);

  // A refill on the drain edge wins, so the slot stays full with the new entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      rd   <= '0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      rd   <= load_rd;
      data <= load_data;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-channel register-file writeback arbiter (ALU and load unit), one write per cycle.
// Optional same-cycle bypass for an uncontended request is enabled by defining WB_BYPASS_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int N = XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [N-1:0]          alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [N-1:0]          mem_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [N-1:0]          rf_wdata,
  output logic [NUM_REGS-1:0]   pend_mask
);

  logic                  alu_full, mem_full;
  logic [REG_ADDR_W-1:0] alu_slot_rd, mem_slot_rd;
  logic [N-1:0]          alu_slot_data, mem_slot_data;
  logic                  alu_load, mem_load;
  logic                  grant_alu, grant_mem, contended;
  logic                  bypass_alu, bypass_mem;
  req_e                  older, rr_ptr, sel;

  wb_slot #(.N(N)) u_alu_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (alu_load),
    .clear     (grant_alu),
    .load_rd   (alu_rd),
    .load_data (alu_data),
    .full      (alu_full),
    .rd        (alu_slot_rd),
    .data      (alu_slot_data)
  );

  wb_slot #(.N(N)) u_mem_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (mem_load),
    .clear     (grant_mem),
    .load_rd   (mem_rd),
    .load_data (mem_data),
    .full      (mem_full),
    .rd        (mem_slot_rd),
    .data      (mem_slot_data)
  );

  // Equal destinations must retire in arrival order; otherwise alternate fairly.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    sel       = REQ_ALU;
    contended = alu_full && mem_full;
    if (contended) begin
      sel       = (alu_slot_rd == mem_slot_rd) ? older : rr_ptr;
      grant_alu = (sel == REQ_ALU);
      grant_mem = (sel == REQ_MEM);
    end else begin
      grant_alu = alu_full;
      grant_mem = mem_full;
    end
  end

`ifdef WB_BYPASS_EN
  assign bypass_alu = rst && !alu_full && !mem_full && alu_valid && !mem_valid && (alu_rd != '0);
  assign bypass_mem = rst && !alu_full && !mem_full && mem_valid && !alu_valid && (mem_rd != '0);
`else
  assign bypass_alu = 1'b0;
  assign bypass_mem = 1'b0;
`endif

  assign alu_ready = rst && (!alu_full || grant_alu);
  assign mem_ready = rst && (!mem_full || grant_mem);

  // rd = 0 transfers complete the handshake but never occupy a slot.
  assign alu_load = alu_valid && alu_ready && (alu_rd != '0) && !bypass_alu;
  assign mem_load = mem_valid && mem_ready && (mem_rd != '0) && !bypass_mem;

  always_comb begin
    rf_we    = 1'b0;
    rf_rd    = '0;
    rf_wdata = '0;
    if (grant_alu) begin
      rf_we    = 1'b1;
      rf_rd    = alu_slot_rd;
      rf_wdata = alu_slot_data;
    end else if (grant_mem) begin
      rf_we    = 1'b1;
      rf_rd    = mem_slot_rd;
      rf_wdata = mem_slot_data;
    end else if (bypass_alu) begin
      rf_we    = 1'b1;
      rf_rd    = alu_rd;
      rf_wdata = alu_data;
    end else if (bypass_mem) begin
      rf_we    = 1'b1;
      rf_rd    = mem_rd;
      rf_wdata = mem_data;
    end
  end

  assign pend_mask = (alu_full ? rd_onehot(alu_slot_rd) : '0)
                   | (mem_full ? rd_onehot(mem_slot_rd) : '0);

  // The entry that stays put while the other is freshly loaded becomes the older one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      older  <= REQ_ALU;
      rr_ptr <= REQ_ALU;
    end else begin
      if (contended)
        rr_ptr <= grant_alu ? REQ_MEM : REQ_ALU;
      if (alu_load && mem_load)
        older <= REQ_ALU;
      else if (alu_load && mem_full && !grant_mem)
        older <= REQ_MEM;
      else if (mem_load && alu_full && !grant_alu)
        older <= REQ_ALU;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a timestamped reference model predicts writes and readiness.
module tb_wb_arbiter;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          alu_valid = 1'b0, mem_valid = 1'b0;
  logic [4:0]    alu_rd = '0, mem_rd = '0;
  logic [N-1:0]  alu_data = '0, mem_data = '0;
  logic          alu_ready, mem_ready, rf_we;
  logic [4:0]    rf_rd;
  logic [N-1:0]  rf_wdata;
  logic [31:0]   pend_mask;

  always #5 clk = ~clk;

  wb_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata),
    .pend_mask (pend_mask)
  );

  typedef struct {
    logic [4:0]   rd;
    logic [N-1:0] data;
  } wr_t;

  typedef struct {
    bit           full;
    logic [4:0]   rd;
    logic [N-1:0] data;
    int unsigned  seq;
  } ent_t;

  wr_t         exp_q[$];
  ent_t        m_slot[2];
  int          m_rr = 0;
  int unsigned m_seq = 0;
  int          checks = 0;
  int          passes = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: entries carry an arrival stamp; grant chosen from the arbitration rules.
  task automatic modelCycle();
    logic         v[2];
    logic [4:0]   r[2];
    logic [N-1:0] d[2];
    logic [31:0]  exp_pend;
    bit           rdy[2];
    bit           byp;
    int           g;
    v[0] = alu_valid; r[0] = alu_rd; d[0] = alu_data;
    v[1] = mem_valid; r[1] = mem_rd; d[1] = mem_data;
    if (!rst) begin
      for (int c = 0; c < 2; c++) m_slot[c].full = 1'b0;
      m_rr = 0;
      checkOutput("alu_ready_rst", alu_ready, 0);
      checkOutput("mem_ready_rst", mem_ready, 0);
      checkOutput("pend_mask_rst", pend_mask, 0);
      return;
    end
    exp_pend = '0;
    for (int c = 0; c < 2; c++)
      if (m_slot[c].full) exp_pend[m_slot[c].rd] = 1'b1;
    checkOutput("pend_mask", pend_mask, exp_pend);
    g = -1;
    byp = 1'b0;
    if (m_slot[0].full && m_slot[1].full) begin
      if (m_slot[0].rd == m_slot[1].rd) g = (m_slot[0].seq < m_slot[1].seq) ? 0 : 1;
      else g = m_rr;
      m_rr = 1 - g;
    end else if (m_slot[0].full) g = 0;
    else if (m_slot[1].full) g = 1;
    if (g >= 0) exp_q.push_back('{rd: m_slot[g].rd, data: m_slot[g].data});
`ifdef WB_BYPASS_EN
    if (!m_slot[0].full && !m_slot[1].full && (v[0] != v[1])) begin
      int c;
      c = v[0] ? 0 : 1;
      byp = 1'b1;
      if (r[c] != 0) exp_q.push_back('{rd: r[c], data: d[c]});
    end
`endif
    for (int c = 0; c < 2; c++) rdy[c] = !m_slot[c].full || (g == c);
    checkOutput("alu_ready", alu_ready, rdy[0]);
    checkOutput("mem_ready", mem_ready, rdy[1]);
    if (g >= 0) m_slot[g].full = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (!byp && v[c] && rdy[c] && r[c] != 0) begin
        m_slot[c] = '{full: 1'b1, rd: r[c], data: d[c], seq: m_seq};
        m_seq++;
      end
    end
  endtask

  // Called at posedge+1: drive one cycle of inputs, evaluate the model, advance one clock.
  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [N-1:0] ad,
                               input logic mv, input logic [4:0] mrd, input logic [N-1:0] md);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    #1;
    modelCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  // Write-port monitor: every cycle must match the head of the expected queue exactly.
  always @(negedge clk) begin
    wr_t e;
    bit  exp_we;
    if (!rst) begin
      checkOutput("rf_we_in_reset", rf_we, 0);
    end else begin
      exp_we = (exp_q.size() != 0);
      checkOutput("rf_we", rf_we, exp_we);
      if (exp_we) begin
        e = exp_q.pop_front();
        if (rf_we) begin
          checkOutput("rf_rd", rf_rd, e.rd);
          checkOutput("rf_wdata", rf_wdata, e.data);
        end
      end else begin
        checkOutput("rf_rd_idle", rf_rd, 0);
        checkOutput("rf_wdata_idle", rf_wdata, 0);
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    // Reset held with a pending ALU request, then released.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1, 5'd4, 32'h1111_0000, 0, 0, 0);
    rst = 1'b1;
    applyStimulus(1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0);
    idle(2);

    // Both channels streaming distinct destinations.
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 5'd3, 32'hA000_0000 + i, 1, 5'd7, 32'hB000_0000 + i);
    idle(4);

    // Same destination, ALU first.
    applyStimulus(1, 5'd9, 32'h0000_00A9, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 5'd9, 32'h0000_00B9);
    applyStimulus(1, 5'd9, 32'h0000_01A9, 1, 5'd9, 32'h0000_01B9);
    applyStimulus(1, 5'd9, 32'h0000_02A9, 1, 5'd9, 32'h0000_02B9);
    idle(4);

    // Discarded rd = 0 transfer.
    applyStimulus(0, 0, 0, 1, 5'd0, 32'h5555_5555);
    idle(2);

    // Reset pulse with both slots holding requests.
    applyStimulus(1, 5'd10, 32'hCAFE_0010, 1, 5'd11, 32'hCAFE_0011);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    idle(3);

    // Randomised traffic with a narrow rd range to provoke collisions and discards.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) rst = 1'b0;
      else rst = 1'b1;
      applyStimulus($urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom,
                    $urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom);
    end
    rst = 1'b1;
    idle(6);
    checkOutput("drain_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
